// File: rtl/bram_sdp_clr_if.sv
// rtl/bram_sdp_clr_if.sv - write/read port bundle for the simple-dual-port block RAM
interface bram_sdp_clr_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;

    // Controller side: issues writes and reads, receives read results.
    modport master (
        output write_addr, write_enable, write_data,
        output read_addr, read_enable,
        input  read_data, read_valid
    );

    // RAM side.
    modport slave (
        input  write_addr, write_enable, write_data,
        input  read_addr, read_enable,
        output read_data, read_valid
    );
endinterface

// File: rtl/bram_sdp_clr.sv
// rtl/bram_sdp_clr.sv - simple-dual-port RAM with read pipeline, write-first forwarding and clear engine
module bram_sdp_clr #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    DEPTH          = 200,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    READ_LATENCY   = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    output logic              busy_o,
    bram_sdp_clr_if.slave     bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam state_t                RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;

    // Array content at configuration time is the same word the clear engine writes.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_VALUE};

    logic                  idle;
    logic                  sweep_en;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  pre_valid;
    logic [DATA_WIDTH-1:0] pre_data;
    logic                  read_valid_q;
    logic [DATA_WIDTH-1:0] read_data_q;

    // Reset wins over everything: no sweep write, user write or read is taken on a reset edge.
    assign idle        = (state_q == ST_IDLE);
    assign sweep_en    = (state_q == ST_CLEAR) && !reset_i;
    assign wr_in_range = ({1'b0, bus.write_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, bus.read_addr} < DEPTH_EXT);
    assign wr_accept   = idle && !reset_i && bus.write_enable && wr_in_range;
    assign rd_accept   = idle && !reset_i && bus.read_enable;

    assign busy_o = (state_q == ST_CLEAR);

    // Clear engine next state: sweep every address once, then fall back to idle.
    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clear_addr_q == LAST_ADDR) begin
                    state_d      = ST_IDLE;
                    clear_addr_d = '0;
                end else begin
                    clear_addr_d = ADDR_WIDTH'(clear_addr_q + 1'b1);
                end
            end
        endcase
    end

    // Clear engine state and sweep counter; reset restarts the sweep from address 0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= RESET_STATE;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    // Single write port shared by the sweep and the user; the sweep owns it while busy.
    always_ff @(posedge clk_i) begin
        if (sweep_en) begin
            mem_q[clear_addr_q] <= INIT_VALUE;
        end else if (wr_accept) begin
            mem_q[bus.write_addr] <= bus.write_data;
        end
    end

    // Read word at issue time: out-of-range reads give 0, a same-cycle write to the same address wins.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (wr_accept && (bus.write_addr == bus.read_addr)) begin
                rd_word = bus.write_data;
            end else begin
                rd_word = mem_q[bus.read_addr];
            end
        end
    end

    // The word is captured at issue, so later writes or sweeps never reach an in-flight read.
    if (READ_LATENCY >= 2) begin : g_lat2
        logic                  s1_valid_q;
        logic [DATA_WIDTH-1:0] s1_data_q;

        // Extra pipeline stage between the array read and the output register.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_accept;
                if (rd_accept) begin
                    s1_data_q <= rd_word;
                end
            end
        end

        assign pre_valid = s1_valid_q;
        assign pre_data  = s1_data_q;
    end else begin : g_lat1
        assign pre_valid = rd_accept;
        assign pre_data  = rd_word;
    end

    // Output register: strobe for one cycle per completed read, data holds between reads.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
        end else begin
            read_valid_q <= pre_valid;
            if (pre_valid) begin
                read_data_q <= pre_data;
            end
        end
    end

    assign bus.read_valid = read_valid_q;
    assign bus.read_data  = read_data_q;

endmodule

// File: tb/tb_bram_sdp_clr.sv
// tb/tb_bram_sdp_clr.sv - self-checking bench for bram_sdp_clr at read latencies 1 and 2
module tb_bram_sdp_clr;

    localparam int         DW    = 8;
    localparam int         AW    = 8;
    localparam int         DEPTH = 200;
    localparam logic [7:0] INIT  = 8'h96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       clr;
    logic       we;
    logic [7:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [7:0] ra;
    logic       busy1;
    logic       busy2;

    bram_sdp_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    bram_sdp_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    assign bus1.write_addr   = wa;
    assign bus1.write_enable = we;
    assign bus1.write_data   = wd;
    assign bus1.read_addr    = ra;
    assign bus1.read_enable  = re;
    assign bus2.write_addr   = wa;
    assign bus2.write_enable = we;
    assign bus2.write_data   = wd;
    assign bus2.read_addr    = ra;
    assign bus2.read_enable  = re;

    bram_sdp_clr #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1),
        .INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b1)
    ) dut1 (
        .clk_i(clk), .reset_i(rst), .clear_i(clr), .busy_o(busy1), .bus(bus1)
    );

    bram_sdp_clr #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(2),
        .INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b1)
    ) dut2 (
        .clk_i(clk), .reset_i(rst), .clear_i(clr), .busy_o(busy2), .bus(bus2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference ----------------
    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_t;

    logic [7:0] m_mem [256];
    int         m_cyc     = 0;
    int         m_rem     = 0;   // sweep edges still to come
    bit         m_ready   = 1'b0;
    rd_t        q1 [$];
    rd_t        q2 [$];
    logic       ev1, ev2;
    logic [7:0] ed1, ed2;

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = INIT;
        ev1 = 1'b0; ev2 = 1'b0; ed1 = 8'h00; ed2 = 8'h00;
    end

    always @(posedge clk) begin
        logic [7:0] v;
        m_cyc++;
        if (rst) begin
            m_ready = 1'b1;
            m_rem   = DEPTH;
            q1.delete();
            q2.delete();
            ev1 = 1'b0; ev2 = 1'b0; ed1 = 8'h00; ed2 = 8'h00;
        end else begin
            if (m_rem > 0) begin
                m_mem[DEPTH - m_rem] = INIT;
                m_rem--;
            end else begin
                if (re) begin
                    if (int'(ra) >= DEPTH)      v = 8'h00;
                    else if (we && wa == ra)    v = wd;
                    else                        v = m_mem[ra];
                    q1.push_back('{m_cyc, v});
                    q2.push_back('{m_cyc + 1, v});
                end
                if (we && int'(wa) < DEPTH) m_mem[wa] = wd;
                if (clr) m_rem = DEPTH;
            end
            ev1 = 1'b0;
            if (q1.size() > 0 && q1[0].due == m_cyc) begin
                ev1 = 1'b1; ed1 = q1[0].data; void'(q1.pop_front());
            end
            ev2 = 1'b0;
            if (q2.size() > 0 && q2[0].due == m_cyc) begin
                ev2 = 1'b1; ed2 = q2[0].data; void'(q2.pop_front());
            end
        end
    end

    // Every cycle after the first reset, both instances must match the reference.
    always @(negedge clk) begin
        if (m_ready) begin
            check("busy1",  busy1,           m_rem > 0);
            check("busy2",  busy2,           m_rem > 0);
            check("valid1", bus1.read_valid, ev1);
            check("data1",  bus1.read_data,  ed1);
            check("valid2", bus2.read_valid, ev2);
            check("data2",  bus2.read_data,  ed2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic w, input logic [7:0] aw, input logic [7:0] dw,
                       input logic r, input logic [7:0] ar, input logic c);
        we = w; wa = aw; wd = dw; re = r; ra = ar; clr = c;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic count_busy(input string name, input int exp);
        int n;
        n = 0;
        while (busy1 && n < 1000) begin
            n++;
            idle();
        end
        check(name, n, exp);
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
        wa = 8'h00; wd = 8'h00; ra = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_busy",  busy1,           1);
        check("reset_valid", bus1.read_valid, 0);
        check("reset_data",  bus2.read_data,  0);

        // clear after reset, then INIT content at 0, 99, 199
        rst = 1'b0;
        count_busy("busy_len_after_reset", 200);
        cyc(0, 0, 0, 1, 8'd0, 0);   check("init_rd0_valid", bus1.read_valid, 1); check("init_rd0", bus1.read_data, INIT);
        cyc(0, 0, 0, 1, 8'd99, 0);  check("init_rd99", bus1.read_data, INIT);
        cyc(0, 0, 0, 1, 8'd199, 0); check("init_rd199", bus1.read_data, INIT);
        idle();

        // basic and pipelined reads
        cyc(1, 8'd3, 8'hA5, 0, 0, 0);
        cyc(1, 8'd4, 8'h5A, 0, 0, 0);
        cyc(0, 0, 0, 1, 8'd3, 0);   check("pipe_l1_a", bus1.read_data, 8'hA5); check("pipe_l2_none", bus2.read_valid, 0);
        cyc(0, 0, 0, 1, 8'd4, 0);   check("pipe_l1_b", bus1.read_data, 8'h5A); check("pipe_l2_a", bus2.read_data, 8'hA5);
        cyc(0, 0, 0, 1, 8'd3, 0);   check("pipe_l1_c", bus1.read_data, 8'hA5); check("pipe_l2_b", bus2.read_data, 8'h5A);
        idle();                     check("pipe_l1_done", bus1.read_valid, 0); check("pipe_l2_c", bus2.read_data, 8'hA5);
        idle();

        // write-first forwarding, and no forwarding from a later write
        cyc(1, 8'd7, 8'h3C, 1, 8'd7, 0); check("fwd_l1", bus1.read_data, 8'h3C);
        idle();                          check("fwd_l2", bus2.read_data, 8'h3C);
        cyc(0, 0, 0, 1, 8'd7, 0);
        cyc(1, 8'd7, 8'h11, 0, 0, 0);    check("late_wr_l2_valid", bus2.read_valid, 1); check("late_wr_l2", bus2.read_data, 8'h3C);
        cyc(0, 0, 0, 1, 8'd7, 0);        check("new_wr_l1", bus1.read_data, 8'h11);
        idle();

        // out of range
        cyc(1, 8'd250, 8'hEE, 0, 0, 0);
        cyc(0, 0, 0, 1, 8'd250, 0);      check("oor_valid", bus1.read_valid, 1); check("oor_data", bus1.read_data, 8'h00);
        idle();                          check("oor_data_l2", bus2.read_data, 8'h00);

        // clear request with accesses and a second clear during the sweep
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 8'hFF, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        n = 0;
        while (busy1 && n < 1000) begin
            n++;
            case (n)
                3:       cyc(1, 8'd5, 8'h77, 1, 8'd5, 0);
                50:      cyc(0, 0, 0, 0, 0, 1);
                default: idle();
            endcase
            if (n == 3) check("busy_rd_drop_l1", bus1.read_valid, 0);
            if (n == 4) check("busy_rd_drop_l2", bus2.read_valid, 0);
        end
        check("busy_len_clear", n, 200);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 1, 8'(i), 0);
            check("post_clear_rd", bus1.read_data, INIT);
        end
        idle();

        // reset with a read in flight, then reset at sweep address 120
        cyc(1, 8'd10, 8'h42, 0, 0, 0);
        cyc(0, 0, 0, 1, 8'd10, 0);
        cyc(0, 0, 0, 1, 8'd10, 0);       check("pre_reset_data", bus1.read_data, 8'h42);
        rst = 1'b1;
        idle();                          check("rst_valid1", bus1.read_valid, 0); check("rst_data1", bus1.read_data, 0);
                                         check("rst_valid2", bus2.read_valid, 0); check("rst_data2", bus2.read_data, 0);
        idle();                          check("rst_valid2_late", bus2.read_valid, 0);
        rst = 1'b0;
        repeat (120) idle();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        count_busy("busy_len_after_mid_reset", 200);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] a_w, a_r;
            rst = ($urandom_range(0, 799) == 0);
            a_w = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            a_r = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            cyc(1'($urandom_range(0, 1)), a_w, 8'($urandom),
                1'($urandom_range(0, 1)), a_r, ($urandom_range(0, 249) == 0));
        end
        rst = 1'b0;
        repeat (4) idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, expected finish earlier", $time);
        $fatal(1);
    end

endmodule

// File: doc/bram_sdp_clr.md
# bram_sdp_clr

Parametrised simple-dual-port block RAM for the cell-state and generation buffers: one write port, one read port, one clock. Over the basic single-cycle BRAM it adds a selectable read latency (1 or 2), write-first read-during-write forwarding, a read-valid strobe, out-of-range protection, and a hardware clear engine. The clear engine fills the whole array with `INIT_VALUE` after reset or on request, so the board is wiped without the controller sweeping every address.

## Interface
- `DATA_WIDTH`, 8, bits per word
- `DEPTH`, 200, number of words; must be ≥ 2 and ≤ 2**`ADDR_WIDTH`
- `ADDR_WIDTH`, 8, address bits
- `READ_LATENCY`, 1, cycles from read request to data; legal values 1 or 2
- `INIT_VALUE`, 0, word written by the clear engine and used as power-up content
- `CLEAR_ON_RESET`, 1, 1 = clear engine starts automatically after reset

- `clk`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high
- `clear`  in  1  single-cycle clear request
- `busy`  out  1  high while the clear engine runs
- `write_addr`  in  `ADDR_WIDTH`  write address
- `write_enable`  in  1  write strobe
- `write_data`  in  `DATA_WIDTH`  write word
- `read_addr`  in  `ADDR_WIDTH`  read address
- `read_enable`  in  1  read strobe
- `read_data`  out  `DATA_WIDTH`  read word
- `read_valid`  out  1  one-cycle strobe qualifying `read_data`

## Operation
- **Power-up:** every word holds `INIT_VALUE`.
- **Reset values:**
  - `read_data` = 0, `read_valid` = 0.
  - Pipeline valid bits = 0; clear counter = 0.
  - State = CLEAR if `CLEAR_ON_RESET`, else IDLE.
- **State machine:** two states, IDLE and CLEAR; `busy` = (state == CLEAR).
  - IDLE → CLEAR when `clear` = 1.
  - CLEAR: each cycle write `INIT_VALUE` to `memory[clear_addr]` and increment `clear_addr`. After writing address `DEPTH-1`, go to IDLE and reset the counter to 0.
  - A clear takes exactly `DEPTH` cycles.
  - `clear` asserted while in CLEAR is ignored; it does not restart the sweep.
- **User writes:** accepted only in IDLE with `write_addr` < `DEPTH`. Writes are dropped while `busy`=1 or when the address is out of range.
- **User reads:** accepted only in IDLE.
  - A read with `read_enable` while `busy`=1 is dropped and produces no `read_valid`.
  - Out-of-range `read_addr` returns 0 with `read_valid` asserted.
- **Read-during-write, same address, same cycle:** returns the new `write_data` (write-first forwarding).
  - A write issued in a later cycle than the read is not forwarded into an already-issued read, including at `READ_LATENCY`=2.
- **Same cycle as `clear` in IDLE:** the read or write is still accepted, because `busy` is still 0. The write is then overwritten by the sweep.
- **In-flight reads:** reads issued before the clear complete normally; the pipeline is not flushed.
- **`read_data` hold:** holds its last value when no read completes. It is cleared only by reset.
- **Reset mid-clear or mid-read:** aborts everything. In-flight reads never strobe. The sweep restarts from address 0 if `CLEAR_ON_RESET`=1; otherwise memory is left partially cleared.

## Timing
- **Read latency:** a read accepted in cycle N gives `read_data`/`read_valid` in cycle N+`READ_LATENCY`.
- **Throughput:** fully pipelined, one read per cycle. Back-to-back reads give back-to-back `read_valid`.
- **Write latency:** a write in cycle N is visible to a read issued in cycle N (via forwarding) and to any later read.
- **Clear request:** `clear` sampled at edge E gives `busy`=1 from E to E+`DEPTH`. The first accepted user access is at edge E+`DEPTH`+1.
- **Clear on reset:** with `CLEAR_ON_RESET`=1, `busy`=1 from the first reset edge. It stays high through `DEPTH` edges after `reset` falls; holding reset keeps the counter at 0.
- **Timing paths:** no combinational path from inputs to outputs. `busy` is decoded from a state register.

## Test plan
- **Clear after reset:** `CLEAR_ON_RESET`=1, `DEPTH`=200. Release reset → `busy` high for exactly 200 cycles. Then reads of addresses 0, 99 and 199 return `INIT_VALUE` with `read_valid` one cycle later (latency 1).
- **Basic and pipelined reads:** write 0xA5 @ 3 and 0x5A @ 4, then read 3,4,3 on consecutive cycles. Expect 0xA5, 0x5A, 0xA5 on consecutive cycles at latency 1. Repeat at `READ_LATENCY`=2 and check each result is one cycle later.
- **Forwarding:** same cycle, write 0x3C @ 7 and read 7 → read returns 0x3C. Write 0x11 @ 7 one cycle after a read of 7 with latency 2 → that read returns 0x3C.
- **Clear request:** pulse `clear` after filling addresses 0..199 with 0xFF. During `busy`, write 0x77 @ 5 and read 5 → write dropped, no `read_valid`. After `busy` falls, every address reads `INIT_VALUE`. A second `clear` mid-sweep leaves `busy` length unchanged at 200.
- **Out-of-range:** write 0xEE @ 250 → no array word changes. Read 250 → `read_valid`=1, `read_data`=0.
- **Reset mid-operation:** assert reset at sweep address 120 with a read in flight. Expect no `read_valid`, `read_data`=0, and a fresh 200-cycle `busy` after release.
